bpu_npc: RTL

//  Parametrised next-PC unit with a fully-associative branch target buffer (BTB)
//  and 2-bit saturating-counter prediction. Sits in IF: it owns the fetch PC

---
 rtl/npc_pkg.sv | 32 +++
 rtl/bpu_npc_if.sv | 40 ++++
 rtl/bpu_npc_btb.sv | 85 ++++++++
 rtl/bpu_npc.sv | 88 ++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared types and constants for the next-PC unit and its BTB.
// PC values are word addresses (byte address >> 2).
package npc_pkg;

   localparam int PC_W = 30;
   localparam logic [PC_W-1:0] RESET_PC = 30'h0C0D;
   localparam logic [PC_W-1:0] EXC_PC   = 30'h0;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_e;

   typedef struct packed {
      logic            valid;
      logic [PC_W-1:0] tag;
      logic [1:0]      ctr;
      logic [PC_W-1:0] target;
   } btb_entry_t;

   function automatic logic [1:0] ctr_next(
      input logic [1:0] c,
      input logic       up
   );
      if (up)
         return (c == ST) ? ST : c + 2'd1;
      return (c == SNT) ? SNT : c - 2'd1;
   endfunction

endpackage

// File: rtl/bpu_npc_if.sv
// Fetch-side bundle of the next-PC unit: EX resolutions,
// redirects, fetch PC/prediction, flush and perf counters.
interface bpu_npc_if;
   import npc_pkg::*;

   logic            stall;
   logic [PC_W-1:0] if_pc;
   logic            pred_taken;
   logic [PC_W-1:0] pred_target;
   logic            ex_valid;
   logic [PC_W-1:0] ex_pc;
   logic            ex_taken;
   logic [PC_W-1:0] ex_target;
   logic            ex_pred_taken;
   logic [PC_W-1:0] ex_pred_target;
   logic            jump_valid;
   logic [PC_W-1:0] jump_target;
   logic            exc_valid;
   logic [PC_W-1:0] exc_target;
   logic            flush;
   logic [31:0]     perf_lookups;
   logic [31:0]     perf_mispred;

   modport slave (
      input  stall, ex_valid, ex_pc, ex_taken, ex_target,
      input  ex_pred_taken, ex_pred_target,
      input  jump_valid, jump_target, exc_valid, exc_target,
      output if_pc, pred_taken, pred_target, flush,
      output perf_lookups, perf_mispred
   );

   modport master (
      output stall, ex_valid, ex_pc, ex_taken, ex_target,
      output ex_pred_taken, ex_pred_target,
      output jump_valid, jump_target, exc_valid, exc_target,
      input  if_pc, pred_taken, pred_target, flush,
      input  perf_lookups, perf_mispred
   );

endinterface

// File: rtl/bpu_npc_btb.sv
// Fully-associative BTB: comb. lookup, counter update and
// allocation (first invalid entry, else round-robin pointer).
module btb_table
   import npc_pkg::*;
#(
   parameter int ENTRIES = 16,
   localparam int PTR_W = $clog2(ENTRIES)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [PC_W-1:0] lk_pc_i,
   output logic            lk_hit_o,
   output logic            lk_taken_o,
   output logic [PC_W-1:0] lk_target_o,
   input  logic            upd_valid_i,
   input  logic [PC_W-1:0] upd_pc_i,
   input  logic            upd_taken_i,
   input  logic [PC_W-1:0] upd_target_i
);

   btb_entry_t      btb_q [ENTRIES];
   btb_entry_t      btb_d [ENTRIES];
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             upd_hit, free_found;
   logic [PTR_W-1:0] upd_idx, free_idx, alloc_idx;

   always_comb begin
      lk_hit_o    = 1'b0;
      lk_taken_o  = 1'b0;
      lk_target_o = '0;
      for (int i = 0; i < ENTRIES; i++)
         if (btb_q[i].valid && btb_q[i].tag == lk_pc_i) begin
            lk_hit_o    = 1'b1;
            lk_taken_o  = btb_q[i].ctr[1];
            lk_target_o = btb_q[i].target;
         end
   end

   // descending scan so the lowest free index wins
   always_comb begin
      upd_hit    = 1'b0;
      upd_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = 0; i < ENTRIES; i++)
         if (btb_q[i].valid && btb_q[i].tag == upd_pc_i) begin
            upd_hit = 1'b1;
            upd_idx = PTR_W'(i);
         end
      for (int i = ENTRIES - 1; i >= 0; i--)
         if (!btb_q[i].valid) begin
            free_found = 1'b1;
            free_idx   = PTR_W'(i);
         end
   end

   assign alloc_idx = free_found ? free_idx : ptr_q;

   always_comb begin
      btb_d = btb_q;
      ptr_d = ptr_q;
      if (upd_valid_i && upd_hit) begin
         btb_d[upd_idx].ctr = ctr_next(btb_q[upd_idx].ctr, upd_taken_i);
         if (upd_taken_i)
            btb_d[upd_idx].target = upd_target_i;
      end else if (upd_valid_i && upd_taken_i) begin
         btb_d[alloc_idx] = '{valid: 1'b1, tag: upd_pc_i,
                              ctr: WT, target: upd_target_i};
         ptr_d = (ptr_q == PTR_W'(ENTRIES - 1)) ? '0
                                                 : ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++)
            btb_q[i] <= '{valid: 1'b0, tag: '0, ctr: WNT, target: '0};
         ptr_q <= '0;
      end else begin
         btb_q <= btb_d;
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/bpu_npc.sv
// Next-PC unit: fetch PC register, redirect mux, flush, BTB.
// Define BPU_PERF_EN to build the hit/mispredict counters.
module bpu_npc
   import npc_pkg::*;
#(
   parameter int              ENTRIES  = 16,
   parameter logic [PC_W-1:0] RESET_PC = npc_pkg::RESET_PC
) (
   input logic       clk,
   input logic       rst,
   bpu_npc_if.slave  bus
);

   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] seq_pc, fix_pc, btb_tgt, pred_tgt;
   logic            hit, btb_taken, mispred;

   btb_table #(.ENTRIES(ENTRIES)) u_btb (
      .clk          (clk),
      .rst          (rst),
      .lk_pc_i      (pc_q),
      .lk_hit_o     (hit),
      .lk_taken_o   (btb_taken),
      .lk_target_o  (btb_tgt),
      .upd_valid_i  (bus.ex_valid),
      .upd_pc_i     (bus.ex_pc),
      .upd_taken_i  (bus.ex_taken),
      .upd_target_i (bus.ex_target)
   );

   assign seq_pc   = pc_q + PC_W'(1);
   assign pred_tgt = hit ? btb_tgt : seq_pc;

   assign mispred = bus.ex_valid &
                    ((bus.ex_taken != bus.ex_pred_taken) |
                     (bus.ex_taken &
                      (bus.ex_target != bus.ex_pred_target)));
   assign fix_pc  = bus.ex_taken ? bus.ex_target
                                 : bus.ex_pc + PC_W'(1);

   // redirects load even under stall; stall only holds pred/seq
   always_comb begin
      pc_d = pc_q;
      if (bus.exc_valid)
         pc_d = bus.exc_target;
      else if (mispred)
         pc_d = fix_pc;
      else if (bus.jump_valid)
         pc_d = bus.jump_target;
      else if (!bus.stall)
         pc_d = (hit && btb_taken) ? btb_tgt : seq_pc;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         pc_q <= RESET_PC;
      else
         pc_q <= pc_d;
   end

   assign bus.if_pc       = pc_q;
   assign bus.pred_taken  = hit & btb_taken;
   assign bus.pred_target = pred_tgt;
   assign bus.flush       = bus.exc_valid | mispred | bus.jump_valid;

`ifdef BPU_PERF_EN
   logic [31:0] lookups_q, mispred_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lookups_q <= '0;
         mispred_q <= '0;
      end else begin
         if (hit && !bus.stall)
            lookups_q <= lookups_q + 32'd1;
         if (mispred)
            mispred_q <= mispred_q + 32'd1;
      end
   end

   assign bus.perf_lookups = lookups_q;
   assign bus.perf_mispred = mispred_q;
`else
   assign bus.perf_lookups = '0;
   assign bus.perf_mispred = '0;
`endif

endmodule
